// File: rtl/ifetch_req_gen_if.sv
// Instruction-fetch bundle: redirect input, imem request/response channel,
// and the fetch-queue output toward decode.
interface ifetch_req_gen_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  // Fetch unit side
  modport master (
    input  redirect_valid, redirect_pc,
    output req_valid, req_addr,
    input  req_ready,
    input  resp_valid, resp_inst,
    output resp_ready,
    output out_valid, out_pc, out_inst,
    input  out_ready
  );

  // Environment side: front-end control, imem and decode
  modport slave (
    output redirect_valid, redirect_pc,
    input  req_valid, req_addr,
    output req_ready,
    output resp_valid, resp_inst,
    input  resp_ready,
    input  out_valid, out_pc, out_inst,
    output out_ready
  );
endinterface

// File: rtl/ifetch_req_gen.sv
// Instruction-fetch request generator: issues sequential word fetches under a
// credit limit, tags responses with their PC and queues them for decode.
// Redirect restarts at a new PC and discards every response still in flight.
module ifetch_req_gen #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned FQ_DEPTH        = 4
) (
  input  logic             clk,
  input  logic             rst,
  ifetch_req_gen_if.master bus
);
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned FPW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned FCW = $clog2(FQ_DEPTH + 1);
  localparam logic [TPW-1:0] TAG_LAST = TPW'(MAX_OUTSTANDING - 1);
  localparam logic [FPW-1:0] FQ_LAST  = FPW'(FQ_DEPTH - 1);
  localparam logic [FCW-1:0] FQ_FULL  = FCW'(FQ_DEPTH);

  logic [31:0]    pc_q, pc_d;
  logic [CW-1:0]  live_q, live_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [31:0]    tag_mem_q [MAX_OUTSTANDING];
  logic [31:0]    tag_mem_d [MAX_OUTSTANDING];
  logic [TPW-1:0] tag_wr_q, tag_wr_d;
  logic [TPW-1:0] tag_rd_q, tag_rd_d;
  logic [63:0]    fq_mem_q [FQ_DEPTH];
  logic [63:0]    fq_mem_d [FQ_DEPTH];
  logic [FPW-1:0] fq_wr_q, fq_wr_d;
  logic [FPW-1:0] fq_rd_q, fq_rd_d;
  logic [FCW-1:0] fq_cnt_q, fq_cnt_d;

  logic credit_ok;
  logic req_fire;
  logic resp_fire;
  logic resp_drop;
  logic resp_live;
  logic fq_push;
  logic fq_pop;
  logic unused_redirect_lsb;

  // Issue only when a total-outstanding slot exists and every live response
  // already has a reserved fetch-queue entry.
  assign credit_ok = (32'(live_q) + 32'(drop_q) < MAX_OUTSTANDING) &&
                     (32'(live_q) + 32'(fq_cnt_q) < FQ_DEPTH);

  assign bus.req_valid  = !rst && !bus.redirect_valid && credit_ok;
  assign bus.req_addr   = pc_q;
  assign bus.resp_ready = 1'b1;
  assign bus.out_valid  = (fq_cnt_q != '0);
  assign bus.out_pc     = fq_mem_q[fq_rd_q][63:32];
  assign bus.out_inst   = fq_mem_q[fq_rd_q][31:0];

  assign req_fire  = bus.req_valid && bus.req_ready;
  assign resp_fire = bus.resp_valid && bus.resp_ready;
  assign resp_drop = resp_fire && (drop_q != '0);
  assign resp_live = resp_fire && (drop_q == '0);
  assign fq_push   = resp_live && !bus.redirect_valid;
  assign fq_pop    = bus.out_valid && bus.out_ready;

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // Next-state: redirect flushes everything; otherwise issue, retire and pop.
  always_comb begin
    pc_d      = pc_q;
    live_d    = live_q;
    drop_d    = drop_q;
    tag_mem_d = tag_mem_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    fq_mem_d  = fq_mem_q;
    fq_wr_d   = fq_wr_q;
    fq_rd_d   = fq_rd_q;
    fq_cnt_d  = fq_cnt_q;
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
      live_d   = '0;
      // Every live request becomes a drop; this cycle's response, live or
      // not, is consumed here and so leaves the outstanding total.
      drop_d   = CW'(32'(drop_q) + 32'(live_q) - (resp_fire ? 32'd1 : 32'd0));
      tag_wr_d = '0;
      tag_rd_d = '0;
      fq_wr_d  = '0;
      fq_rd_d  = '0;
      fq_cnt_d = '0;
    end else begin
      if (req_fire) begin
        pc_d                = pc_q + 32'd4;
        tag_mem_d[tag_wr_q] = pc_q;
        tag_wr_d            = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TPW'(1);
      end
      if (resp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (fq_push) begin
        tag_rd_d          = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TPW'(1);
        fq_mem_d[fq_wr_q] = {tag_mem_q[tag_rd_q], bus.resp_inst};
        fq_wr_d           = (fq_wr_q == FQ_LAST) ? '0 : fq_wr_q + FPW'(1);
      end
      if (fq_pop) begin
        fq_rd_d = (fq_rd_q == FQ_LAST) ? '0 : fq_rd_q + FPW'(1);
      end
      live_d   = live_q + CW'(req_fire) - CW'(resp_live);
      fq_cnt_d = fq_cnt_q + FCW'(fq_push) - FCW'(fq_pop);
    end
  end

  // State registers; storage arrays carry no reset since counts gate their use.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      live_q   <= '0;
      drop_q   <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      fq_wr_q  <= '0;
      fq_rd_q  <= '0;
      fq_cnt_q <= '0;
    end else begin
      pc_q     <= pc_d;
      live_q   <= live_d;
      drop_q   <= drop_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      fq_wr_q  <= fq_wr_d;
      fq_rd_q  <= fq_rd_d;
      fq_cnt_q <= fq_cnt_d;
    end
    tag_mem_q <= tag_mem_d;
    fq_mem_q  <= fq_mem_d;
  end

  a_fq_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (fq_cnt_q == FQ_FULL) |-> !fq_push);
  a_live_no_underflow: assert property (@(posedge clk) disable iff (rst)
    resp_live |-> (live_q != '0));
  a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
    (32'(live_q) + 32'(drop_q)) <= MAX_OUTSTANDING);
endmodule

// File: tb/tb_ifetch_req_gen.sv
// Bench for ifetch_req_gen: directed vector table, corner-case sequences and
// a randomized run against a queue-based fetch model with a 1-cycle imem.
module tb_ifetch_req_gen;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int unsigned MAX_OUT  = 4;
  localparam int unsigned FQ_D     = 4;

  logic clk;
  logic rst;
  ifetch_req_gen_if bus();

  ifetch_req_gen #(
    .RESET_PC(RESET_PC),
    .MAX_OUTSTANDING(MAX_OUT),
    .FQ_DEPTH(FQ_D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests;
  int unsigned fails;

  // imem pending responses, each stamped with the fetch epoch it belongs to
  typedef struct { logic [31:0] addr; int unsigned epoch; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } fq_t;
  pend_t       pend[$];
  fq_t         mfq[$];
  logic [31:0] exp_pc;
  int unsigned epoch;
  int unsigned stall_pct;
  bit          imem_hold;

  logic        s_req_valid, s_out_valid, s_resp_ready;
  logic [31:0] s_req_addr, s_out_pc, s_out_inst;

  typedef struct {
    bit rr; bit ordy; bit redir; logic [31:0] rpc;
    bit erv; logic [31:0] eaddr; bit eov; logic [31:0] epc;
  } vec_t;
  vec_t vt[16];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already set; drive imem, sample, check, update model.
  task automatic cycle();
    int unsigned live;
    bit          exp_rv;
    pend_t       r;
    if (rst || pend.size() == 0 || imem_hold) bus.resp_valid = 1'b0;
    else bus.resp_valid = ($urandom_range(99) >= stall_pct);
    if (bus.resp_valid) bus.resp_inst = inst_of(pend[0].addr);
    else bus.resp_inst = $urandom;
    #1;
    s_req_valid  = bus.req_valid;
    s_req_addr   = bus.req_addr;
    s_out_valid  = bus.out_valid;
    s_out_pc     = bus.out_pc;
    s_out_inst   = bus.out_inst;
    s_resp_ready = bus.resp_ready;
    if (rst) begin
      chk("req_valid_in_reset", 32'(s_req_valid), 32'd0);
      pend.delete();
      mfq.delete();
      exp_pc = RESET_PC;
      epoch++;
    end else begin
      live = 0;
      foreach (pend[i]) if (pend[i].epoch == epoch) live++;
      exp_rv = !bus.redirect_valid && (pend.size() < MAX_OUT) && (live + mfq.size() < FQ_D);
      chk("req_valid", 32'(s_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", s_req_addr, exp_pc);
      chk("resp_ready", 32'(s_resp_ready), 32'd1);
      chk("out_valid", 32'(s_out_valid), 32'(mfq.size() != 0));
      if (mfq.size() != 0) begin
        chk("out_pc", s_out_pc, mfq[0].pc);
        chk("out_inst", s_out_inst, mfq[0].inst);
        if (bus.out_ready) void'(mfq.pop_front());
      end
      if (bus.resp_valid) begin
        r = pend.pop_front();
        if (!bus.redirect_valid && r.epoch == epoch)
          mfq.push_back('{r.addr, inst_of(r.addr)});
      end
      if (bus.redirect_valid) begin
        mfq.delete();
        epoch++;
        exp_pc = {bus.redirect_pc[31:2], 2'b00};
      end else if (exp_rv && bus.req_ready) begin
        pend.push_back('{exp_pc, epoch});
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.req_ready = 1'b0;
    bus.out_ready = 1'b0;
    imem_hold = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_first_out(input string nm, input logic [31:0] pc);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      cycle();
      if (s_out_valid) begin
        found = 1'b1;
        chk(nm, s_out_pc, pc);
      end
    end
    chk({nm, "_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; epoch = 0; stall_pct = 0; imem_hold = 1'b0;
    exp_pc = RESET_PC;
    rst = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.req_ready = 1'b0; bus.out_ready = 1'b0;
    bus.resp_valid = 1'b0; bus.resp_inst = '0;
    @(negedge clk);

    // Directed table: credit stall with out_ready=0, drain, redirect with pop
    //           rr ordy redir rpc         erv eaddr        eov epc
    vt[0]  = '{1, 0, 0, 32'h0,    1, 32'h100,  0, 32'h0};
    vt[1]  = '{1, 0, 0, 32'h0,    1, 32'h104,  0, 32'h0};
    vt[2]  = '{1, 0, 0, 32'h0,    1, 32'h108,  1, 32'h100};
    vt[3]  = '{1, 0, 0, 32'h0,    1, 32'h10C,  1, 32'h100};
    vt[4]  = '{1, 0, 0, 32'h0,    0, 32'h0,    1, 32'h100};
    vt[5]  = '{1, 1, 0, 32'h0,    0, 32'h0,    1, 32'h100};
    vt[6]  = '{1, 1, 0, 32'h0,    1, 32'h110,  1, 32'h104};
    vt[7]  = '{1, 1, 0, 32'h0,    1, 32'h114,  1, 32'h108};
    vt[8]  = '{1, 1, 0, 32'h0,    1, 32'h118,  1, 32'h10C};
    vt[9]  = '{1, 1, 0, 32'h0,    1, 32'h11C,  1, 32'h110};
    vt[10] = '{1, 1, 0, 32'h0,    1, 32'h120,  1, 32'h114};
    vt[11] = '{1, 1, 1, 32'h2003, 0, 32'h0,    1, 32'h118};
    vt[12] = '{1, 1, 0, 32'h0,    1, 32'h2000, 0, 32'h0};
    vt[13] = '{1, 1, 0, 32'h0,    1, 32'h2004, 0, 32'h0};
    vt[14] = '{1, 1, 0, 32'h0,    1, 32'h2008, 1, 32'h2000};
    vt[15] = '{1, 1, 0, 32'h0,    1, 32'h200C, 1, 32'h2004};

    do_reset();
    chk("post_reset_req_addr", bus.req_addr, RESET_PC);
    chk("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 16; k++) begin
      bus.req_ready = vt[k].rr;
      bus.out_ready = vt[k].ordy;
      bus.redirect_valid = vt[k].redir;
      bus.redirect_pc = vt[k].rpc;
      cycle();
      chk($sformatf("tbl%0d_req_valid", k), 32'(s_req_valid), 32'(vt[k].erv));
      if (vt[k].erv) chk($sformatf("tbl%0d_req_addr", k), s_req_addr, vt[k].eaddr);
      chk($sformatf("tbl%0d_out_valid", k), 32'(s_out_valid), 32'(vt[k].eov));
      if (vt[k].eov) begin
        chk($sformatf("tbl%0d_out_pc", k), s_out_pc, vt[k].epc);
        chk($sformatf("tbl%0d_out_inst", k), s_out_inst, inst_of(vt[k].epc));
      end
    end
    bus.redirect_valid = 1'b0;

    // Sustained stream: one request and, after two cycles, one output per cycle
    do_reset();
    bus.req_ready = 1'b1; bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("stream_req", s_req_valid ? s_req_addr : 32'hDEAD_DEAD, RESET_PC + 32'(4 * k));
      if (k >= 2) chk("stream_out", s_out_valid ? s_out_pc : 32'hDEAD_DEAD, RESET_PC + 32'(4 * (k - 2)));
    end

    // Redirect with three requests in flight
    do_reset();
    bus.req_ready = 1'b1; bus.out_ready = 1'b1; imem_hold = 1'b1;
    repeat (3) cycle();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_2003;
    cycle();
    bus.redirect_valid = 1'b0; imem_hold = 1'b0;
    cycle();
    chk("redir3_req_valid", 32'(s_req_valid), 32'd1);
    chk("redir3_req_addr", s_req_addr, 32'h0000_2000);
    wait_first_out("redir3_first_out", 32'h0000_2000);

    // Redirect coinciding with a response and an output pop
    do_reset();
    bus.req_ready = 1'b1; bus.out_ready = 1'b0;
    cycle();
    cycle();
    imem_hold = 1'b1;
    cycle();
    imem_hold = 1'b0; bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_3000;
    cycle();
    chk("redir_pop_out_valid", 32'(s_out_valid), 32'd1);
    chk("redir_pop_out_pc", s_out_pc, RESET_PC);
    bus.redirect_valid = 1'b0;
    cycle();
    chk("redir_flush_out_valid", 32'(s_out_valid), 32'd0);
    chk("redir_pop_req_addr", s_req_addr, 32'h0000_3000);
    wait_first_out("redir_pop_first_out", 32'h0000_3000);

    // PC wrap at the top of the address space, then reset mid-stream
    do_reset();
    bus.req_ready = 1'b1; bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
    cycle();
    bus.redirect_valid = 1'b0;
    cycle();
    chk("wrap_req0", s_req_valid ? s_req_addr : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_req1", s_req_valid ? s_req_addr : 32'hDEAD_DEAD, 32'h0000_0000);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("midrst_out_valid", 32'(s_out_valid), 32'd0);
    chk("midrst_req_addr", s_req_addr, RESET_PC);

    // Randomized traffic with imem stalls, redirects and occasional resets
    stall_pct = 30;
    repeat (3000) begin
      bus.req_ready = ($urandom_range(99) < 70);
      bus.out_ready = ($urandom_range(99) < 70);
      bus.redirect_valid = ($urandom_range(99) < 3);
      bus.redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      rst = ($urandom_range(999) < 3);
      cycle();
    end
    rst = 1'b0;
    bus.redirect_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
